// File: rtl/g1_chain_walker.sv
// Chain-following lookup controller for one G1 table search stage: walks the
// next_index chain until a match, the chain terminator or the hop limit.
module g1_chain_walker #(
  parameter int                       INDEX_BIT_LEN  = 11,
  parameter int                       PACKET_BIT_LEN = 104,
  parameter logic [INDEX_BIT_LEN-1:0] NULL_INDEX     = INDEX_BIT_LEN'(11'h7FF),
  parameter int                       MAX_HOPS       = 16,
  parameter int                       HOP_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PACKET_BIT_LEN-1:0] in_tuple,
  input  logic [INDEX_BIT_LEN-1:0]  in_index,
  output logic [INDEX_BIT_LEN-1:0]  tbl_search_index,
  output logic [PACKET_BIT_LEN-1:0] tbl_tuple,
  input  logic                      tbl_match,
  input  logic [INDEX_BIT_LEN-1:0]  tbl_ruleID,
  input  logic [INDEX_BIT_LEN-1:0]  tbl_next_index,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_hit,
  output logic [INDEX_BIT_LEN-1:0]  res_ruleID,
  output logic [HOP_W-1:0]          res_hops
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state, state_d;
  logic [HOP_W-1:0] hop_cnt;
  logic             hop_limit;
  logic             chain_end;

  assign hop_limit = (hop_cnt == HOP_W'(MAX_HOPS));
  // A match has priority over both terminating conditions.
  assign chain_end = tbl_match || (tbl_next_index == NULL_INDEX) || hop_limit;

  assign in_ready  = (state == S_IDLE);
  assign res_valid = (state == S_DONE);

  // NOTE: every variable in a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (in_valid)  state_d = S_ISSUE;
      S_ISSUE:                state_d = S_WAIT;
      S_WAIT:                 state_d = chain_end ? S_DONE : S_ISSUE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // The table-facing registers double as the latched tuple and current index:
  // they are loaded on accept, so hop 1 is already on the bus in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_search_index <= '0;
      tbl_tuple        <= '0;
      hop_cnt          <= '0;
      res_hit          <= 1'b0;
      res_ruleID       <= '0;
      res_hops         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            tbl_search_index <= in_index;
            tbl_tuple        <= in_tuple;
            hop_cnt          <= '0;
          end
        end
        S_ISSUE: begin
          if (!hop_limit) hop_cnt <= hop_cnt + 1'b1;
        end
        S_WAIT: begin
          if (tbl_match) begin
            res_hit    <= 1'b1;
            res_ruleID <= tbl_ruleID;
            res_hops   <= hop_cnt;
          end else if (chain_end) begin
            res_hit    <= 1'b0;
            res_ruleID <= '0;
            res_hops   <= hop_cnt;
          end else begin
            tbl_search_index <= tbl_next_index;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_g1_chain_walker.sv
// Directed bench for g1_chain_walker with a registered table model and
// MAX_HOPS=4 so the hop limit is reachable in a short chain.
module tb_g1_chain_walker;

  localparam int         IW   = 11;
  localparam int         PW   = 104;
  localparam int         HW   = 8;
  localparam int         MAXH = 4;
  localparam logic [IW-1:0] NULLI = 11'h7FF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [PW-1:0] in_tuple;
  logic [IW-1:0] in_index;
  logic [IW-1:0] tbl_search_index;
  logic [PW-1:0] tbl_tuple;
  logic          tbl_match;
  logic [IW-1:0] tbl_ruleID, tbl_next_index;
  logic          res_valid, res_ready, res_hit;
  logic [IW-1:0] res_ruleID;
  logic [HW-1:0] res_hops;

  g1_chain_walker #(
    .INDEX_BIT_LEN(IW), .PACKET_BIT_LEN(PW), .NULL_INDEX(NULLI),
    .MAX_HOPS(MAXH), .HOP_W(HW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_tuple(in_tuple), .in_index(in_index),
    .tbl_search_index(tbl_search_index), .tbl_tuple(tbl_tuple),
    .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_ruleID(res_ruleID), .res_hops(res_hops)
  );

  always #5 clk = ~clk;

  // Table contents; an entry matches only when its key equals the driven tuple.
  logic          mem_match [2048];
  logic [PW-1:0] mem_key   [2048];
  logic [IW-1:0] mem_rule  [2048];
  logic [IW-1:0] mem_next  [2048];

  always @(posedge clk) begin
    tbl_match      <= mem_match[tbl_search_index] && (mem_key[tbl_search_index] == tbl_tuple);
    tbl_ruleID     <= mem_rule[tbl_search_index];
    tbl_next_index <= mem_next[tbl_search_index];
  end

  localparam logic [PW-1:0] K1 = 104'h0123456789ABCDEF0011223344;
  localparam logic [PW-1:0] K2 = K1 ^ 104'd1;

  typedef struct {
    string              name;
    logic [PW-1:0]      tuple;
    logic [IW-1:0]      index;
    logic               hit;
    logic [IW-1:0]      rule;
    logic [HW-1:0]      hops;
    int                 lat;
    logic [3:0][IW-1:0] tr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [PW-1:0] tuple, input logic [IW-1:0] index,
                         input logic hit, input logic [IW-1:0] rule, input logic [HW-1:0] hops,
                         input int lat, input logic [IW-1:0] t0, t1, t2, t3);
    vec_t v;
    v.name = name; v.tuple = tuple; v.index = index; v.hit = hit; v.rule = rule;
    v.hops = hops; v.lat = lat;
    v.tr[0] = t0; v.tr[1] = t1; v.tr[2] = t2; v.tr[3] = t3;
    vecs.push_back(v);
  endtask

  task automatic set_entry(input int idx, input logic m, input logic [PW-1:0] key,
                           input logic [IW-1:0] rule, input logic [IW-1:0] nxt);
    mem_match[idx] = m; mem_key[idx] = key; mem_rule[idx] = rule; mem_next[idx] = nxt;
  endtask

  // Called at or after a negedge; returns #1 after the accepting edge.
  task automatic do_req(input logic [PW-1:0] tuple, input logic [IW-1:0] index);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1; in_tuple = tuple; in_index = index;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until res_valid, recording the index
  // presented in each issue (odd) cycle.
  task automatic collect(output int lat, output logic [7:0][IW-1:0] tr, output int ntr,
                         output logic [PW-1:0] tup1, output bit busy_ok);
    int c = 0;
    ntr = 0; busy_ok = 1'b1; tr = '0; tup1 = '0;
    forever begin
      @(negedge clk);
      c++;
      if (res_valid || c > 40) break;
      if (in_ready) busy_ok = 1'b0;
      if (c == 1) tup1 = tbl_tuple;
      if ((c % 2) == 1 && ntr < 8) begin
        tr[ntr] = tbl_search_index;
        ntr++;
      end
    end
    lat = c;
    check("res_valid_seen", res_valid, 1'b1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("idle_after_handshake", in_ready, 1'b1);
    check("valid_drop_after_handshake", res_valid, 1'b0);
  endtask

  initial begin
    int                 lat, ntr;
    logic [7:0][IW-1:0] tr;
    logic [PW-1:0]      tup1;
    bit                 busy_ok;
    bit                 stale;

    in_valid = 1'b0; in_tuple = '0; in_index = '0; res_ready = 1'b0;
    for (int i = 0; i < 2048; i++) set_entry(i, 1'b0, '0, '0, NULLI);
    set_entry(20, 1'b1, K1, 11'd42, NULLI);
    set_entry(5,  1'b0, '0, '0, 11'd9);
    set_entry(9,  1'b0, '0, '0, 11'd12);
    set_entry(12, 1'b1, K1, 11'd7, NULLI);
    set_entry(30, 1'b0, '0, '0, 11'd31);
    set_entry(3,  1'b0, '0, '0, 11'd4);
    set_entry(4,  1'b0, '0, '0, 11'd3);
    set_entry(40, 1'b0, '0, '0, 11'd41);
    set_entry(41, 1'b0, '0, '0, 11'd42);
    set_entry(42, 1'b0, '0, '0, 11'd43);
    set_entry(43, 1'b1, K1, 11'd99, NULLI);
    set_entry(70, 1'b1, K1, 11'h555, 11'd71);

    add_vec("direct_hit",     K1, 11'd20, 1'b1, 11'd42,  8'd1, 3, 11'd20, 0, 0, 0);
    add_vec("tuple_mismatch", K2, 11'd20, 1'b0, 11'd0,   8'd1, 3, 11'd20, 0, 0, 0);
    add_vec("chain_hit",      K1, 11'd5,  1'b1, 11'd7,   8'd3, 7, 11'd5, 11'd9, 11'd12, 0);
    add_vec("chain_miss",     K1, 11'd30, 1'b0, 11'd0,   8'd2, 5, 11'd30, 11'd31, 0, 0);
    add_vec("hop_limit",      K1, 11'd3,  1'b0, 11'd0,   8'd4, 9, 11'd3, 11'd4, 11'd3, 11'd4);
    add_vec("hit_at_limit",   K1, 11'd40, 1'b1, 11'd99,  8'd4, 9, 11'd40, 11'd41, 11'd42, 11'd43);
    add_vec("null_start",     K1, NULLI,  1'b0, 11'd0,   8'd1, 3, NULLI, 0, 0, 0);
    add_vec("match_priority", K1, 11'd70, 1'b1, 11'h555, 8'd1, 3, 11'd70, 0, 0, 0);

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_hit", res_hit, 1'b0);
    check("rst_res_ruleID", res_ruleID, '0);
    check("rst_res_hops", res_hops, '0);
    check("rst_tbl_search_index", tbl_search_index, '0);
    check("rst_tbl_tuple", tbl_tuple, '0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_req(vecs[i].tuple, vecs[i].index);
      collect(lat, tr, ntr, tup1, busy_ok);
      check({vecs[i].name, "_hit"},     res_hit, vecs[i].hit);
      check({vecs[i].name, "_ruleID"},  res_ruleID, vecs[i].rule);
      check({vecs[i].name, "_hops"},    res_hops, vecs[i].hops);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_tuple"},   tup1, vecs[i].tuple);
      check({vecs[i].name, "_busy"},    busy_ok, 1'b1);
      check({vecs[i].name, "_reads"},   ntr, int'(vecs[i].hops));
      for (int k = 0; k < int'(vecs[i].hops) && k < 4; k++)
        check($sformatf("%s_index%0d", vecs[i].name, k), tr[k], vecs[i].tr[k]);
      handshake();
    end

    // Back-pressure: stalled result with a second request waiting.
    do_req(K1, 11'd20);
    collect(lat, tr, ntr, tup1, busy_ok);
    check("bp_latency", lat, 3);
    in_valid = 1'b1; in_tuple = K1; in_index = 11'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_hit", res_hit, 1'b1);
      check("bp_res_ruleID", res_ruleID, 11'd42);
      check("bp_res_hops", res_hops, 8'd1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_tbl_index_hold", tbl_search_index, 11'd20);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    check("bp_second_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(lat, tr, ntr, tup1, busy_ok);
    check("bp_second_hit", res_hit, 1'b1);
    check("bp_second_ruleID", res_ruleID, 11'd7);
    check("bp_second_hops", res_hops, 8'd3);
    check("bp_second_latency", lat, 7);
    handshake();

    // Reset during WAIT of hop 2 abandons the lookup.
    do_req(K1, 11'd5);
    repeat (4) @(negedge clk);
    check("mid_hop2_index", tbl_search_index, 11'd9);
    check("mid_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_tbl_index", tbl_search_index, '0);
    check("mid_rst_res_hops", res_hops, '0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || !in_ready) stale = 1'b1;
    end
    check("post_rst_no_stale", stale, 1'b0);
    do_req(K1, 11'd20);
    collect(lat, tr, ntr, tup1, busy_ok);
    check("post_rst_hit", res_hit, 1'b1);
    check("post_rst_ruleID", res_ruleID, 11'd42);
    check("post_rst_latency", lat, 3);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/g1_chain_walker.md
# g1_chain_walker

Lookup controller that sits directly upstream of one G1 table search stage. It accepts a packet tuple and a starting entry index, then drives the table's `search_index`/`tupleData` inputs. It follows the `next_index` chain returned by the table, one hop at a time, until one of three things happens: a match, the chain terminator, or the hop limit. It then presents a single result (hit/miss, ruleID, hop count) to the downstream merge logic through a valid/ready handshake.

## Interface
Parameters:
- `INDEX_BIT_LEN`, 11, width of entry indices and ruleIDs.
- `PACKET_BIT_LEN`, 104, width of the packet tuple.
- `NULL_INDEX`, 11'h7FF, value of `next_index` that terminates a chain.
- `MAX_HOPS`, 16, maximum number of table reads per lookup (1..255).
- `HOP_W`, 8, width of the hop counter and of `res_hops`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a lookup request is present.
- `in_ready` out 1: walker can accept a request.
- `in_tuple` in PACKET_BIT_LEN: packet tuple.
- `in_index` in INDEX_BIT_LEN: first entry of the chain.
- `tbl_search_index` out INDEX_BIT_LEN: index driven to the table stage.
- `tbl_tuple` out PACKET_BIT_LEN: tuple driven to the table stage.
- `tbl_match` in 1: table match flag.
- `tbl_ruleID` in INDEX_BIT_LEN: table ruleID.
- `tbl_next_index` in INDEX_BIT_LEN: table chain pointer.
- `res_valid` out 1: result is present.
- `res_ready` in 1: downstream accepts the result.
- `res_hit` out 1: 1 = match found.
- `res_ruleID` out INDEX_BIT_LEN: matched ruleID; 0 on a miss.
- `res_hops` out HOP_W: number of table reads performed.

## Operation
- Table stage contract: `tbl_match`, `tbl_ruleID` and `tbl_next_index` are registered. The value returned for an index driven in cycle N is valid in cycle N+1 only. The walker samples these inputs only in the WAIT state.
- State machine: IDLE, ISSUE, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch `in_tuple` into the tuple register and `in_index` into the current-index register;
  - set hop counter to 0;
  - go to ISSUE.
- ISSUE: drive the current index and the latched tuple to the table; increment the hop counter; go to WAIT.
- WAIT: sample the table outputs. Checks are applied in this priority order:
  - `tbl_match`=1 → hit; `res_ruleID` takes `tbl_ruleID`; go to DONE.
  - `tbl_next_index`==NULL_INDEX → miss; go to DONE.
  - hop counter==MAX_HOPS → miss (chain truncated); go to DONE.
  - otherwise → the current index takes `tbl_next_index`; go to ISSUE.
- DONE: `res_valid`=1. All result outputs are held stable until `res_ready`=1. On `res_valid`&&`res_ready`, go to IDLE.
- `tbl_search_index` and `tbl_tuple` are registered. They keep their last value outside ISSUE/WAIT.
- A miss forces `res_ruleID`=0 and `res_hit`=0.
- `in_index`==NULL_INDEX is not special-cased. The walker still performs one read of that index.
- Hop counter saturates at MAX_HOPS and never wraps.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) puts the FSM in IDLE and sets these outputs:
  - `in_ready`=1 (combinational from IDLE);
  - `res_valid`=0, `res_hit`=0, `res_ruleID`=0, `res_hops`=0;
  - `tbl_search_index`=0, `tbl_tuple`=0.
- If reset is asserted mid-lookup, the lookup is abandoned with no result emitted. The first request after reset is accepted in the first IDLE cycle.
- Request accepted at edge E0:
  - hop k has its index on `tbl_search_index` in cycle 2k−1 and its result sampled in cycle 2k (cycles counted from E0);
  - `res_valid` rises in cycle 2k+1 for a lookup ending at hop k.
  - Minimum latency from accept to `res_valid` is therefore 3 cycles. A full-length miss takes 2·MAX_HOPS+1 cycles.
- `in_ready`=0 from the accept edge until the cycle after the result handshake. Back-to-back lookups therefore have a gap of at least one IDLE cycle.
- `res_valid` stays high across `res_ready`=0 stalls of any length. A new request cannot be accepted while the walker is stalled.
- `in_valid` while busy is ignored. The requester must hold the request until `in_ready`.

## Test plan
- **Direct hit.** Entry 5 has match=1, ruleID=42. Request `in_index`=5 → `res_valid` 3 cycles after accept; `res_hit`=1, `res_ruleID`=42, `res_hops`=1.
- **Chain hit.** 5→9→12, match only at 12 (ruleID=7) → `tbl_search_index` sequence 5, 9, 12; result hit, ruleID=7, hops=3, `res_valid` at cycle 7.
- **Chain miss.** 5→9→NULL_INDEX, no match → `res_hit`=0, `res_ruleID`=0, `res_hops`=2.
- **Hop limit.** MAX_HOPS=4 with a cyclic chain 3→4→3… and no match → miss, `res_hops`=4, `res_valid` at cycle 9.
- **Back-pressure.** `res_ready`=0 for 10 cycles with a second request asserted throughout → result outputs stay stable, `in_ready`=0; after the handshake, the second request is accepted the next cycle.
- **Reset mid-walk.** Assert `rst_n`=0 during WAIT of hop 2 → `res_valid`=0 immediately; after release `in_ready`=1 and no stale result is emitted.
